// File: rtl/debug_mem_reader_if.sv
// Bundle of the three links the debug memory reader touches: the debug
// command side (start/busy/done), the data-memory debug read port and the
// UART transmitter byte handshake.
interface debug_mem_reader_if;
  // command side
  logic        start;
  logic        busy;
  logic        done;
  // data-memory debug read port
  logic        debug_on;
  logic        stop_debug;
  logic [31:0] debug_read_mem;
  logic [31:0] mem_debug_data;
  // UART transmitter
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;

  // The reader itself.
  modport master (
    input  start,
    input  mem_debug_data,
    input  tx_done,
    output busy,
    output done,
    output debug_on,
    output stop_debug,
    output debug_read_mem,
    output tx_data,
    output tx_start
  );

  // Everything around the reader (command decoder, memory stage, UART TX).
  modport slave (
    output start,
    output mem_debug_data,
    output tx_done,
    input  busy,
    input  done,
    input  debug_on,
    input  stop_debug,
    input  debug_read_mem,
    input  tx_data,
    input  tx_start
  );
endinterface

// File: rtl/debug_mem_reader.sv
// Debug memory dump engine: freezes the pipeline, walks N_WORDS addresses of
// the data memory through its debug read port and streams every word to the
// UART transmitter as four bytes, most significant byte first.
module debug_mem_reader #(
  parameter int unsigned N_WORDS   = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'h0000_0004,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic clk,
  input  logic rst,
  debug_mem_reader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FREEZE  = 3'd1,
    S_ADDR    = 3'd2,
    S_CAPTURE = 3'd3,
    S_SEND    = 3'd4,
    S_WAIT_TX = 3'd5,
    S_FINISH  = 3'd6
  } state_t;

  // Index of the final word and final latency count, sized to their counters.
  localparam logic [15:0] LAST_WORD = 16'(N_WORDS - 1);
  localparam logic [2:0]  LAST_LAT  = 3'(READ_LAT - 1);

  // State and datapath registers
  state_t      r_state;
  logic [15:0] r_word_cnt;
  logic [1:0]  r_byte_cnt;
  logic [2:0]  r_lat_cnt;
  logic [31:0] r_shift;
  logic [31:0] r_addr;

  // Registered outputs
  logic [7:0]  r_tx_data;
  logic        r_tx_start;
  logic        r_busy;
  logic        r_done;
  logic        r_freeze;

  // Next-state values
  state_t      w_state_nxt;
  logic [15:0] w_word_nxt;
  logic [1:0]  w_byte_nxt;
  logic [2:0]  w_lat_nxt;
  logic [31:0] w_shift_nxt;
  logic [31:0] w_addr_nxt;

  // Next-state and datapath decisions for the dump sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word_cnt;
    w_byte_nxt  = r_byte_cnt;
    w_lat_nxt   = r_lat_cnt;
    w_shift_nxt = r_shift;
    w_addr_nxt  = r_addr;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_FREEZE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_FREEZE: begin
        w_addr_nxt  = BASE_ADDR;
        w_word_nxt  = 16'd0;
        w_byte_nxt  = 2'd0;
        w_lat_nxt   = 3'd0;
        w_state_nxt = S_ADDR;
      end

      S_ADDR: begin
        // The address is held while the memory settles for READ_LAT cycles.
        if (r_lat_cnt == LAST_LAT) begin
          w_state_nxt = S_CAPTURE;
        end else begin
          w_lat_nxt = r_lat_cnt + 3'd1;
        end
      end

      S_CAPTURE: begin
        // Only point at which the returned memory word is sampled.
        w_shift_nxt = bus.mem_debug_data;
        w_byte_nxt  = 2'd0;
        w_state_nxt = S_SEND;
      end

      S_SEND: begin
        // tx_done seen in this cycle belongs to no outstanding byte.
        w_state_nxt = S_WAIT_TX;
      end

      S_WAIT_TX: begin
        if (bus.tx_done) begin
          w_shift_nxt = {r_shift[23:0], 8'h00};
          w_byte_nxt  = r_byte_cnt + 2'd1;
          if (r_byte_cnt != 2'd3) begin
            w_state_nxt = S_SEND;
          end else if (r_word_cnt == LAST_WORD) begin
            w_state_nxt = S_FINISH;
          end else begin
            // Address arithmetic wraps modulo 2^32 by construction.
            w_addr_nxt  = r_addr + ADDR_STEP;
            w_word_nxt  = r_word_cnt + 16'd1;
            w_lat_nxt   = 3'd0;
            w_state_nxt = S_ADDR;
          end
        end else begin
          w_state_nxt = S_WAIT_TX;
        end
      end

      S_FINISH: begin
        // Return everything to its idle values; a start here is dropped.
        w_addr_nxt  = BASE_ADDR;
        w_word_nxt  = 16'd0;
        w_byte_nxt  = 2'd0;
        w_lat_nxt   = 3'd0;
        w_shift_nxt = 32'h0000_0000;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_addr_nxt  = BASE_ADDR;
        w_word_nxt  = 16'd0;
        w_byte_nxt  = 2'd0;
        w_lat_nxt   = 3'd0;
        w_shift_nxt = 32'h0000_0000;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_word_cnt <= 16'd0;
      r_byte_cnt <= 2'd0;
      r_lat_cnt  <= 3'd0;
      r_shift    <= 32'h0000_0000;
      r_addr     <= BASE_ADDR;
    end else begin
      r_state    <= w_state_nxt;
      r_word_cnt <= w_word_nxt;
      r_byte_cnt <= w_byte_nxt;
      r_lat_cnt  <= w_lat_nxt;
      r_shift    <= w_shift_nxt;
      r_addr     <= w_addr_nxt;
    end
  end

  // Outputs registered from the next state so each one is glitch-free and
  // lines up with the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_freeze   <= 1'b0;
    end else begin
      r_busy     <= (w_state_nxt != S_IDLE);
      r_freeze   <= (w_state_nxt != S_IDLE);
      r_done     <= (w_state_nxt == S_FINISH);
      r_tx_start <= (w_state_nxt == S_SEND);
      if (w_state_nxt == S_SEND) begin
        r_tx_data <= w_shift_nxt[31:24];
      end else if (w_state_nxt == S_IDLE) begin
        r_tx_data <= 8'h00;
      end else begin
        r_tx_data <= r_tx_data;
      end
    end
  end

  assign bus.tx_data        = r_tx_data;
  assign bus.tx_start       = r_tx_start;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.debug_on       = r_freeze;
  assign bus.stop_debug     = r_freeze;
  assign bus.debug_read_mem = r_addr;

endmodule
